// File: rtl/qbus_ram_slave.sv
// Q-bus memory target: latches the address on SYNC, decodes a local RAM window,
// serves DATI/DATO(B)/DATIO cycles and answers with RPLY after a programmable delay.
module qbus_ram_slave #(
    parameter logic [21:0] BASE_ADDR = 22'o0,
    parameter int          AW        = 13,
    parameter int          RPLY_DLY  = 2
) (
    input  logic        pin_clk,
    input  logic        reset,
    input  logic        pin_init_n,
    input  logic [15:0] pin_ad_n,
    input  logic [5:0]  pin_a_n,
    input  logic        pin_bs_n,
    input  logic        pin_sync_n,
    input  logic        pin_din_n,
    input  logic        pin_dout_n,
    input  logic        pin_wtbt_n,
    input  logic        pin_iako_n,
    output logic [15:0] ad_out_n,
    output logic        ad_oe,
    output logic        rply_oe
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RPLY} state_t;

    state_t      state_reg, state_next;
    logic        s_sync_reg, s_din_reg, s_dout_reg, s_init_reg, sync_d_reg;
    logic [3:0]  cnt_reg, cnt_next;
    logic [21:0] adr_reg;
    logic        bs_reg;
    logic        is_read_reg, is_read_next;
    logic        rply_oe_reg, rply_oe_next;
    logic        ad_oe_reg, ad_oe_next;
    logic [15:0] rd_data_reg;
    logic        latch_addr, mem_re, mem_we;
    logic        sync_rise, sel, strobe;
    logic [1:0]  byte_en;

    logic [15:0] mem [0:(2**AW)-1];

    wire [AW-1:0] idx     = adr_reg[AW:1];
    wire [15:0]   wr_data = ~pin_ad_n;

    assign sync_rise = s_sync_reg & ~sync_d_reg;
    assign sel       = ~bs_reg & pin_iako_n & (adr_reg[21:AW+1] == BASE_ADDR[21:AW+1]);
    assign strobe    = is_read_reg ? s_din_reg : s_dout_reg;

    // Byte lane enables: WTBT in the data phase selects a single byte by adr[0].
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_byte_en
            assign byte_en[gi] = pin_wtbt_n | (adr_reg[0] == 1'(gi));
        end
    endgenerate

    always_ff @(posedge pin_clk) begin
        if (reset) begin
            s_sync_reg  <= 1'b0;
            s_din_reg   <= 1'b0;
            s_dout_reg  <= 1'b0;
            s_init_reg  <= 1'b0;
            sync_d_reg  <= 1'b0;
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            adr_reg     <= 22'd0;
            bs_reg      <= 1'b0;
            is_read_reg <= 1'b0;
            rply_oe_reg <= 1'b0;
            ad_oe_reg   <= 1'b0;
        end else begin
            s_sync_reg  <= ~pin_sync_n;
            s_din_reg   <= ~pin_din_n;
            s_dout_reg  <= ~pin_dout_n;
            s_init_reg  <= ~pin_init_n;
            sync_d_reg  <= s_sync_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            is_read_reg <= is_read_next;
            rply_oe_reg <= rply_oe_next;
            ad_oe_reg   <= ad_oe_next;
            if (latch_addr) begin
                adr_reg <= {~pin_a_n, ~pin_ad_n};
                bs_reg  <= ~pin_bs_n;
            end
        end
    end

    // RAM: registered read, byte-lane write; contents survive reset and INIT.
    always_ff @(posedge pin_clk) begin
        if (mem_re)
            rd_data_reg <= mem[idx];
        if (mem_we) begin
            for (int b = 0; b < 2; b++)
                if (byte_en[b])
                    mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        is_read_next = is_read_reg;
        rply_oe_next = rply_oe_reg;
        ad_oe_next   = ad_oe_reg;
        latch_addr   = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        // INIT and a dropped SYNC abort whatever is in flight, pending write included.
        if (s_init_reg || (state_reg != IDLE && !s_sync_reg)) begin
            state_next   = IDLE;
            rply_oe_next = 1'b0;
            ad_oe_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sync_rise) begin
                        latch_addr = 1'b1;
                        state_next = ADDR;
                    end
                end
                ADDR: begin
                    if (sel && s_din_reg) begin
                        mem_re       = 1'b1;
                        ad_oe_next   = 1'b1;
                        is_read_next = 1'b1;
                        cnt_next     = 4'(RPLY_DLY);
                        state_next   = WAIT;
                    end else if (sel && s_dout_reg) begin
                        is_read_next = 1'b0;
                        cnt_next     = 4'(RPLY_DLY);
                        state_next   = WAIT;
                    end
                end
                WAIT: begin
                    if (!strobe) begin
                        ad_oe_next = 1'b0;
                        state_next = ADDR;
                    end else if (cnt_reg == 4'd0) begin
                        mem_we       = ~is_read_reg;
                        rply_oe_next = 1'b1;
                        state_next   = RPLY;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                RPLY: begin
                    if (!strobe) begin
                        rply_oe_next = 1'b0;
                        ad_oe_next   = 1'b0;
                        state_next   = ADDR;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign ad_oe    = ad_oe_reg;
    assign rply_oe  = rply_oe_reg;
    assign ad_out_n = ad_oe_reg ? ~rd_data_reg : 16'hFFFF;

endmodule
